// File: rtl/sample_scoreboard.sv
// sample_scoreboard: in-order checker between a reference stream and a
// measured stream that may arrive with different latencies. Reference samples
// wait in a small FIFO; each measured sample is compared against the oldest
// buffered reference (or against ref_data directly when the FIFO is empty and
// both arrive together). Compare results, counters and the verdict are
// registered one cycle after the measured sample.
//
// Handshake: the reference side is valid/ready. A sample transfers when
// ref_valid & ref_ready at a rising edge; ref_valid while ref_ready is low is
// not stalled but dropped and flagged (overflow). The measured side has no
// back-pressure: every meas_valid cycle is consumed.
module sample_scoreboard #(
  parameter int DATAWIDTH = 16,
  parameter int DEPTH     = 16,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [DATAWIDTH-1:0] ref_data,
  input  logic                 ref_valid,
  output logic                 ref_ready,
  input  logic [DATAWIDTH-1:0] meas_data,
  input  logic                 meas_valid,
  output logic                 mismatch,
  output logic [CNTWIDTH-1:0]  err_count,
  output logic [CNTWIDTH-1:0]  match_count,
  output logic [DATAWIDTH-1:0] first_err_ref,
  output logic [DATAWIDTH-1:0] first_err_meas,
  output logic [CNTWIDTH-1:0]  first_err_index,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 pass
);

  // Index bits plus one wrap bit so full and empty can be told apart.
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PASSING = 2'd1,
    ST_FAILED  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  logic                 mismatch_q, mismatch_d;
  logic [CNTWIDTH-1:0]  err_count_q, err_count_d;
  logic [CNTWIDTH-1:0]  match_count_q, match_count_d;
  logic [CNTWIDTH-1:0]  cmp_idx_q, cmp_idx_d;
  logic [DATAWIDTH-1:0] fe_ref_q, fe_ref_d;
  logic [DATAWIDTH-1:0] fe_meas_q, fe_meas_d;
  logic [CNTWIDTH-1:0]  fe_idx_q, fe_idx_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic                 bypass;
  logic                 do_cmp;
  logic                 cmp_fail;
  logic                 ovf_evt;
  logic                 unf_evt;
  logic                 fail_evt;
  logic [DATAWIDTH-1:0] cmp_ref;

  // FIFO status, handshake and per-cycle events; clear masks every event.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees the slot the push lands in.
    ref_ready  = !fifo_full | meas_valid;
    bypass     = !clear & meas_valid & fifo_empty & ref_valid;
    pop        = !clear & meas_valid & !fifo_empty;
    push       = !clear & ref_valid & ref_ready & !bypass;
    ovf_evt    = !clear & ref_valid & !ref_ready;
    unf_evt    = !clear & meas_valid & fifo_empty & !ref_valid;
    do_cmp     = pop | bypass;
    cmp_ref    = fifo_empty ? ref_data : mem_q[rd_ptr_q[AW-1:0]];
    cmp_fail   = do_cmp & (cmp_ref != meas_data);
    fail_evt   = cmp_fail | ovf_evt | unf_evt;
  end

  // Next value of pointers, counters, capture registers and sticky flags.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mismatch_d    = 1'b0;
    err_count_d   = err_count_q;
    match_count_d = match_count_q;
    cmp_idx_d     = cmp_idx_q;
    fe_ref_d      = fe_ref_q;
    fe_meas_d     = fe_meas_q;
    fe_idx_d      = fe_idx_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    if (clear) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      err_count_d   = '0;
      match_count_d = '0;
      cmp_idx_d     = '0;
      fe_ref_d      = '0;
      fe_meas_d     = '0;
      fe_idx_d      = '0;
      overflow_d    = 1'b0;
      underflow_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      mismatch_d = cmp_fail;
      if (do_cmp) begin
        if (cmp_idx_q != '1) cmp_idx_d = cmp_idx_q + CNTWIDTH'(1);
        if (cmp_fail) begin
          if (err_count_q != '1) err_count_d = err_count_q + CNTWIDTH'(1);
          // err_count saturates and never returns to zero, so zero means
          // no failure has been recorded since reset/clear.
          if (err_count_q == '0) begin
            fe_ref_d  = cmp_ref;
            fe_meas_d = meas_data;
            fe_idx_d  = cmp_idx_q;
          end
        end else if (match_count_q != '1) begin
          match_count_d = match_count_q + CNTWIDTH'(1);
        end
      end
      if (ovf_evt) overflow_d  = 1'b1;
      if (unf_evt) underflow_d = 1'b1;
    end
  end

  // Verdict FSM next state; FAILED is absorbing until reset or clear.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fail_evt)    state_d = ST_FAILED;
          else if (do_cmp) state_d = ST_PASSING;
        end
        ST_PASSING: begin
          if (fail_evt) state_d = ST_FAILED;
        end
        ST_FAILED: state_d = ST_FAILED;
        default:   state_d = ST_FAILED;
      endcase
    end
  end

  // Control and status registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mismatch_q    <= 1'b0;
      err_count_q   <= '0;
      match_count_q <= '0;
      cmp_idx_q     <= '0;
      fe_ref_q      <= '0;
      fe_meas_q     <= '0;
      fe_idx_q      <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mismatch_q    <= mismatch_d;
      err_count_q   <= err_count_d;
      match_count_q <= match_count_d;
      cmp_idx_q     <= cmp_idx_d;
      fe_ref_q      <= fe_ref_d;
      fe_meas_q     <= fe_meas_d;
      fe_idx_q      <= fe_idx_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // Reference storage; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= ref_data;
  end

  assign mismatch        = mismatch_q;
  assign err_count       = err_count_q;
  assign match_count     = match_count_q;
  assign first_err_ref   = fe_ref_q;
  assign first_err_meas  = fe_meas_q;
  assign first_err_index = fe_idx_q;
  assign overflow        = overflow_q;
  assign underflow       = underflow_q;
  assign pass            = (state_q == ST_PASSING);

endmodule
